// File: rtl/mem_pkg.sv
// Shared definitions for data-memory responders: RV32I funct3 width codes,
// the responder state encoding and lane helpers (byte enables, alignment).
package mem_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    // Byte-lane enables for a store of the given width at byte offset off.
    function automatic logic [3:0] byte_en(input logic [2:0] access, input logic [1:0] off);
        case (access)
            ACC_B, ACC_BU: return 4'b0001 << off;
            ACC_H, ACC_HU: return 4'b0011 << off;
            default:       return 4'b1111;
        endcase
    endfunction

    // Halfwords need an even offset, words a zero offset; bytes never fault.
    function automatic logic misaligned(input logic [2:0] access, input logic [1:0] off);
        case (access)
            ACC_H, ACC_HU: return off[0];
            ACC_W:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational byte/half lane steering for a 32-bit word memory port.
//   access   : funct3 width code
//   off      : byte offset within the word
//   st_data  : LSB-aligned store data      -> st_lanes : data replicated on all lanes
//   ld_word  : raw word read from memory   -> ld_data  : selected lane, sign/zero extended
module mem_lane
    import mem_pkg::*;
(
    input  logic [2:0]  access,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    output logic [31:0] st_lanes,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sext;

    assign ld_byte = ld_word[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    assign sext    = ~access[2];   // LBU/LHU carry bit 2 set

    // Replicating lets the byte enables alone pick where the store lands.
    always_comb begin
        st_lanes = st_data;
        case (access)
            ACC_B, ACC_BU: st_lanes = {4{st_data[7:0]}};
            ACC_H, ACC_HU: st_lanes = {2{st_data[15:0]}};
            default:       st_lanes = st_data;
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        case (access)
            ACC_B, ACC_BU: ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
            ACC_H, ACC_HU: ld_data = {{16{sext & ld_half[15]}}, ld_half};
            default:       ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised RAM behind the CPU load/store port
// with a fixed number of wait states. Faulting requests are flagged, not run.
//   clk, rst        : clock, asynchronous active-low reset
//   load, store     : request strobes, held by the core while stall=1
//   access          : funct3 width code
//   addr, data_in   : byte address, LSB-aligned store data
//   data_out        : aligned/extended load result, valid in DONE only
//   stall           : holds the core until the access completes
//   fault           : one-cycle error pulse in DONE
module dmem_resp
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  access,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        fault
);

    localparam int          IDXW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    resp_state_t      state;
    logic [3:0]       cnt;
    logic             stall_q;
    logic             ld_q;
    logic [2:0]       acc_q;
    logic [1:0]       off_q;
    logic [IDXW-1:0]  idx_q;
    logic [31:0]      wdata_q;

    logic [3:0][7:0]  ram [DEPTH_WORDS];

    logic             req, flt, out_rng, bad_code;
    logic [31:0]      rel;
    logic [31:0]      rdata, wlanes, ld_ext;
    logic [3:0]       be;

    // Request classification, evaluated on the live inputs in IDLE.
    assign req      = load | store;
    assign rel      = addr - BASE_ADDR;
    assign out_rng  = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= END_ADDR);
    assign bad_code = (access == 3'b011) || (access == 3'b110) || (access == 3'b111) ||
                      (store && (access == ACC_BU || access == ACC_HU));
    assign flt      = bad_code || misaligned(access, addr[1:0]) || out_rng || (load && store);

    // Only IDLE drives stall combinationally; reset overrides everything.
    assign stall    = rst & (((state == IDLE) & req) | stall_q);

    assign rdata    = ram[idx_q];
    assign be       = byte_en(acc_q, off_q);

    mem_lane u_lane (
        .access   (acc_q),
        .off      (off_q),
        .st_data  (wdata_q),
        .st_lanes (wlanes),
        .ld_word  (rdata),
        .ld_data  (ld_ext)
    );

    // RAM has no reset; a reset during WAIT returns state to IDLE first,
    // so the pending write never happens.
    always_ff @(posedge clk) begin
        if (state == WAIT && cnt == 4'd0 && !ld_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[idx_q][b] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            stall_q  <= 1'b0;
            data_out <= 32'd0;
            fault    <= 1'b0;
            ld_q     <= 1'b0;
            acc_q    <= 3'd0;
            off_q    <= 2'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        ld_q    <= load;
                        acc_q   <= access;
                        off_q   <= addr[1:0];
                        idx_q   <= IDXW'(rel >> 2);
                        wdata_q <= data_in;
                        if (flt) begin
                            state    <= DONE;
                            fault    <= 1'b1;
                            data_out <= 32'd0;
                        end else begin
                            state   <= WAIT;
                            cnt     <= 4'(WAIT_CYCLES - 1);
                            stall_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        stall_q  <= 1'b0;
                        data_out <= ld_q ? ld_ext : 32'd0;
                        fault    <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Unconditional: the request still held here is not a new one.
                    state    <= IDLE;
                    data_out <= 32'd0;
                    fault    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
